// File: rtl/hog_window_fetch.sv
// hog_window_fetch: 4-row circular line buffer feeding the hog stage with
// {top, bot, left, right} neighbour words in raster order, with replication
// of the nearest edge pixel at the image borders.
module hog_window_fetch #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 160,
  parameter int IMG_H = 120
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PIX_W-1:0]   pix_in,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               request,
  output logic [4*PIX_W-1:0] o_data,
  output logic               ready,
  output logic               frame_end
);

  // Row counters are at least 2 bits so their low bits select one of 4 banks.
  localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 4) ? $clog2(IMG_H) : 2;
  localparam int DW = $clog2(IMG_H + 1);

  logic [PIX_W-1:0] mem [4][IMG_W];

  logic [CW-1:0] in_col;
  logic [RW-1:0] in_row;
  logic [DW-1:0] rows_done;
  logic [CW-1:0] out_col;
  logic [RW-1:0] out_row;
  logic          run_q;

  logic          avail;
  logic          issue;
  logic          accept;
  logic          last_word;
  logic          in_col_wrap;
  logic          out_col_wrap;
  logic [1:0]    top_bank;
  logic [1:0]    bot_bank;
  logic [1:0]    ctr_bank;
  logic [CW-1:0] left_col;
  logic [CW-1:0] right_col;

  // Output may run once the row below the centre is complete, or once the
  // whole frame is buffered (bottom row replicates itself).
  assign avail = (32'(rows_done) >= 32'(out_row) + 32'd2) || (rows_done == DW'(IMG_H));

  // Writer stays at most two rows ahead of the centre row so the bank holding
  // the row above the centre is never overwritten while still needed.
  assign in_ready = run_q && (32'(rows_done) < 32'(out_row) + 32'd3)
                          && (32'(rows_done) < 32'(IMG_H));

  assign accept       = in_valid && in_ready;
  assign issue        = request && avail;
  assign in_col_wrap  = (in_col == CW'(IMG_W - 1));
  assign out_col_wrap = (out_col == CW'(IMG_W - 1));
  assign last_word    = (out_row == RW'(IMG_H - 1)) && out_col_wrap;

  assign top_bank  = 2'((out_row == '0) ? out_row : out_row - RW'(1));
  assign bot_bank  = 2'((out_row == RW'(IMG_H - 1)) ? out_row : out_row + RW'(1));
  assign ctr_bank  = 2'(out_row);
  assign left_col  = (out_col == '0) ? out_col : out_col - CW'(1);
  assign right_col = out_col_wrap ? out_col : out_col + CW'(1);

  // Pixel storage; contents need no reset because counters gate every read.
  always_ff @(posedge clk) begin
    if (accept) mem[2'(in_row)][in_col] <= pix_in;
  end

  // Holds in_ready low until the first clock after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) run_q <= 1'b0;
    else      run_q <= 1'b1;
  end

  // Write-side position; cleared together with the read side at frame end.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_col    <= '0;
      in_row    <= '0;
      rows_done <= '0;
    end else if (issue && last_word) begin
      in_col    <= '0;
      in_row    <= '0;
      rows_done <= '0;
    end else if (accept) begin
      if (in_col_wrap) begin
        in_col    <= '0;
        in_row    <= (in_row == RW'(IMG_H - 1)) ? '0 : in_row + RW'(1);
        rows_done <= rows_done + DW'(1);
      end else begin
        in_col <= in_col + CW'(1);
      end
    end
  end

  // Read-side centre position, advancing once per issued word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_col <= '0;
      out_row <= '0;
    end else if (issue) begin
      if (last_word) begin
        out_col <= '0;
        out_row <= '0;
      end else if (out_col_wrap) begin
        out_col <= '0;
        out_row <= out_row + RW'(1);
      end else begin
        out_col <= out_col + CW'(1);
      end
    end
  end

  // Registered neighbour word; o_data holds between transfers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_data    <= '0;
      ready     <= 1'b0;
      frame_end <= 1'b0;
    end else begin
      ready     <= issue;
      frame_end <= issue && last_word;
      if (issue) begin
        o_data <= {mem[top_bank][out_col], mem[bot_bank][out_col],
                   mem[ctr_bank][left_col], mem[ctr_bank][right_col]};
      end
    end
  end

endmodule
